// File: rtl/divider_seq.sv
// Sequential restoring integer divider, signed or unsigned, one quotient bit per clock.
// Latency: WIDTH+2 edges from accepted start to dne (2 edges when the divisor is zero).
// No backpressure: start is accepted only while busy=0, is ignored otherwise, and q/r hold until the next result.
module divider_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             dne,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;      // partial remainder (magnitude)
   logic [WIDTH-1:0] dvd;      // dividend bits shift out the top, quotient bits shift in at the bottom
   logic [WIDTH-1:0] mag_b;    // divisor magnitude
   logic [WIDTH-1:0] a_raw;    // untouched dividend, returned as remainder on divide-by-zero
   logic             q_neg;
   logic             r_neg;
   logic             b_zero;

   // Operand signs and magnitudes at capture time; |-2^(WIDTH-1)| naturally
   // becomes the unsigned pattern 2^(WIDTH-1) under two's-complement negate.
   logic             a_neg_in;
   logic             b_neg_in;
   logic [WIDTH-1:0] mag_a_in;
   logic [WIDTH-1:0] mag_b_in;

   assign a_neg_in = is_signed & a[WIDTH-1];
   assign b_neg_in = is_signed & b[WIDTH-1];
   assign mag_a_in = a_neg_in ? -a : a;
   assign mag_b_in = b_neg_in ? -b : b;

   // Restoring step: the shifted remainder needs one extra bit before the
   // trial subtract; when the subtract succeeds the difference fits WIDTH bits.
   logic [WIDTH:0]   trial;
   logic             ge;
   logic [WIDTH-1:0] diff;

   assign trial = {rem, dvd[WIDTH-1]};
   assign ge    = (trial >= {1'b0, mag_b});
   assign diff  = trial[WIDTH-1:0] - mag_b;

   // Control FSM plus datapath registers; outputs are registered and only change at FIX.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         mag_b    <= '0;
         a_raw    <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         b_zero   <= 1'b0;
         busy     <= 1'b0;
         dne      <= 1'b0;
         q        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
      end else begin
         dne <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_raw  <= a;
                  rem    <= '0;
                  dvd    <= mag_a_in;
                  mag_b  <= mag_b_in;
                  q_neg  <= a_neg_in ^ b_neg_in;
                  r_neg  <= a_neg_in;
                  b_zero <= (b == '0);
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= (b == '0) ? FIX : CALC;
               end
            end
            CALC: begin
               rem <= ge ? diff : trial[WIDTH-1:0];
               dvd <= {dvd[WIDTH-2:0], ge};
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_ITER) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (b_zero) begin
                  q        <= '1;
                  r        <= a_raw;
                  div_zero <= 1'b1;
               end else begin
                  q        <= q_neg ? -dvd : dvd;
                  r        <= r_neg ? -rem : rem;
                  div_zero <= 1'b0;
               end
               dne   <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq at WIDTH=32 and WIDTH=8.
// Directed handshake/arithmetic cases followed by randomised sweeps against an arithmetic model.
module tb_divider_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        st32, sg32, busy32, dne32, dz32;
   logic [31:0] a32, b32, q32o, r32o;
   logic        st8, sg8, busy8, dne8, dz8;
   logic [7:0]  a8, b8, q8o, r8o;

   divider_seq #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .start(st32), .is_signed(sg32), .a(a32), .b(b32),
      .busy(busy32), .dne(dne32), .q(q32o), .r(r32o), .div_zero(dz32)
   );

   divider_seq #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(st8), .is_signed(sg8), .a(a8), .b(b8),
      .busy(busy8), .dne(dne8), .q(q8o), .r(r8o), .div_zero(dz8)
   );

   int nvec = 0;
   int nfail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q, r, a, b;
      logic        dz;
      int          t0;
      int          lat;
   } exp_t;

   exp_t sb32[$];
   exp_t sb8[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s got %0h want %0h", tag, obs, expv);
      end
   endtask

   // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
   function automatic void model(input int w, input bit s, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] qo, output logic [31:0] ro, output logic dzo);
      logic [63:0] mask, ua, ub;
      longint sa, sbv, qq, rr;
      mask = (64'd1 << w) - 64'd1;
      ua = {32'd0, av} & mask;
      ub = {32'd0, bv} & mask;
      if (ub == 64'd0) begin
         qo = mask[31:0];
         ro = ua[31:0];
         dzo = 1'b1;
      end else begin
         dzo = 1'b0;
         if (s) begin
            sa = $signed(ua);
            sbv = $signed(ub);
            if (ua[w-1]) sa = sa - (longint'(1) << w);
            if (ub[w-1]) sbv = sbv - (longint'(1) << w);
            qq = sa / sbv;
            rr = sa % sbv;
         end else begin
            qq = longint'(ua / ub);
            rr = longint'(ua % ub);
         end
         qo = 32'(qq) & mask[31:0];
         ro = 32'(rr) & mask[31:0];
      end
   endfunction

   function automatic logic [31:0] rnd_op(input int w);
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = $urandom_range(0, 15);
         1:       v = -($urandom_range(0, 15));
         2:       v = 32'd1 << (w - 1);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue32(input bit s, input logic [31:0] av, input logic [31:0] bv);
      exp_t e;
      bit   idle;
      idle = !busy32;
      sg32 = s; a32 = av; b32 = bv; st32 = 1'b1;
      model(32, s, av, bv, e.q, e.r, e.dz);
      e.a = av; e.b = bv;
      e.lat = e.dz ? 1 : 33;
      tick;
      st32 = 1'b0; a32 = $urandom; b32 = $urandom; sg32 = 1'($urandom);
      e.t0 = cyc;
      if (idle) sb32.push_back(e);
   endtask

   task automatic issue8(input bit s, input logic [31:0] av, input logic [31:0] bv);
      exp_t e;
      bit   idle;
      idle = !busy8;
      sg8 = s; a8 = av[7:0]; b8 = bv[7:0]; st8 = 1'b1;
      model(8, s, av, bv, e.q, e.r, e.dz);
      e.a = av & 32'hFF; e.b = bv & 32'hFF;
      e.lat = e.dz ? 1 : 9;
      tick;
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
      e.t0 = cyc;
      if (idle) sb8.push_back(e);
   endtask

   task automatic wait32(input string tag);
      int k;
      k = 0;
      do begin tick; k++; end while (!dne32 && k < 200);
      chk(tag, dne32, 1);
   endtask

   task automatic wait8(input string tag);
      int k;
      k = 0;
      do begin tick; k++; end while (!dne8 && k < 100);
      chk(tag, dne8, 1);
   endtask

   // Scoreboard pop and compare on every 32-bit result.
   exp_t        m32;
   logic [63:0] prod32;
   always @(negedge clk) begin
      if (!rst && dne32) begin
         chk("sb32_nonempty", sb32.size() != 0, 1);
         if (sb32.size() != 0) begin
            m32 = sb32.pop_front();
            chk("q32", q32o, m32.q);
            chk("r32", r32o, m32.r);
            chk("dz32", dz32, m32.dz);
            chk("lat32", cyc - m32.t0, m32.lat);
            if (!m32.dz) begin
               prod32 = {32'd0, q32o} * {32'd0, m32.b} + {32'd0, r32o};
               chk("inv32", prod32[31:0], m32.a);
            end
         end
      end
   end

   // Scoreboard pop and compare on every 8-bit result.
   exp_t        m8;
   logic [63:0] prod8;
   always @(negedge clk) begin
      if (!rst && dne8) begin
         chk("sb8_nonempty", sb8.size() != 0, 1);
         if (sb8.size() != 0) begin
            m8 = sb8.pop_front();
            chk("q8", q8o, m8.q);
            chk("r8", r8o, m8.r);
            chk("dz8", dz8, m8.dz);
            chk("lat8", cyc - m8.t0, m8.lat);
            if (!m8.dz) begin
               prod8 = {56'd0, q8o} * {32'd0, m8.b} + {56'd0, r8o};
               chk("inv8", prod8 & 64'hFF, m8.a);
            end
         end
      end
   end

   initial begin
      int nb;
      int nd;
      rst = 1'b1;
      st32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
      st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
      tick; tick;
      rst = 1'b0;
      chk("rst_busy", busy32, 0);
      chk("rst_dne", dne32, 0);
      chk("rst_q", q32o, 0);
      chk("rst_r", r32o, 0);
      chk("rst_dz", dz32, 0);
      chk("rst_busy8", busy8, 0);

      // Unsigned 100/7 with busy-length and hold checks.
      issue32(0, 32'd100, 32'd7);
      nb = 0;
      while (busy32 && nb < 100) begin nb++; tick; end
      chk("busy_cycles", nb, 33);
      chk("dne_after_busy", dne32, 1);
      chk("u100_7_q", q32o, 14);
      chk("u100_7_r", r32o, 2);
      chk("u100_7_dz", dz32, 0);
      tick; tick;
      chk("hold_q", q32o, 14);
      chk("hold_r", r32o, 2);
      chk("hold_dne", dne32, 0);

      // Signed cases.
      issue32(1, 32'hFFFFFFF9, 32'd2);
      wait32("w_s1");
      chk("sm7_2_q", q32o, 32'hFFFFFFFD);
      chk("sm7_2_r", r32o, 32'hFFFFFFFF);
      issue32(1, 32'd7, 32'hFFFFFFFE);
      wait32("w_s2");
      chk("s7_m2_q", q32o, 32'hFFFFFFFD);
      chk("s7_m2_r", r32o, 32'd1);

      // Divide by zero then back-to-back 9/3.
      issue32(0, 32'h1234, 32'd0);
      wait32("w_dz");
      chk("dz_q", q32o, 32'hFFFFFFFF);
      chk("dz_r", r32o, 32'h1234);
      chk("dz_flag", dz32, 1);
      issue32(0, 32'd9, 32'd3);
      wait32("w_9_3");
      chk("n9_3_dz", dz32, 0);
      chk("n9_3_q", q32o, 3);
      chk("n9_3_r", r32o, 0);

      // Signed overflow.
      issue32(1, 32'h80000000, 32'hFFFFFFFF);
      wait32("w_ovf");
      chk("ovf_q", q32o, 32'h80000000);
      chk("ovf_r", r32o, 0);
      chk("ovf_dz", dz32, 0);

      // Start while busy is ignored.
      issue32(0, 32'd50, 32'd5);
      repeat (5) tick;
      st32 = 1'b1; a32 = 32'd1000; b32 = 32'd3;
      tick;
      st32 = 1'b0;
      wait32("w_ign");
      chk("ign_q", q32o, 10);
      chk("ign_r", r32o, 0);

      // Start in the dne cycle; monitor checks the 34-edge latency.
      issue32(0, 32'd1000, 32'd3);
      wait32("w_b2b");
      chk("b2b_q", q32o, 333);
      chk("b2b_r", r32o, 1);

      // Reset during CALC iteration 10 aborts with no dne.
      issue32(0, 32'd77, 32'd5);
      repeat (10) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      sb32.delete();
      chk("abort_busy", busy32, 0);
      chk("abort_q", q32o, 0);
      chk("abort_dne", dne32, 0);
      nd = 0;
      repeat (40) begin tick; if (dne32) nd++; end
      chk("abort_no_dne", nd, 0);

      // Randomised sweeps.
      for (int i = 0; i < 1000; i++) begin
         issue32(1'($urandom), rnd_op(32), rnd_op(32));
         wait32("w_rnd32");
      end
      for (int i = 0; i < 1000; i++) begin
         issue8(1'($urandom), rnd_op(8), rnd_op(8));
         wait8("w_rnd8");
      end

      tick; tick;
      chk("sb32_drained", sb32.size(), 0);
      chk("sb8_drained", sb8.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
